memory_stage: RTL

- MEM stage of the 19-bit pipelined core, directly downstream of the execute stage.
- Consumes the EX/MEM outputs: RegWrite, MemWrite, ResultSrc, RD, WriteData, ALUResult and PC+1.
- Runs loads and stores against a variable-latency data memory over a req/ready handshake, and stalls upstream while an access is pending.
- Holds the MEM/WB pipeline register that feeds writeback.

---
 rtl/memory_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// MEM stage of the 19-bit pipelined core: data-memory handshake, upstream stall and MEM/WB register.
// Optional performance counters are compiled in when MEM_STAGE_PERF_EN is defined.
module memory_stage #(
   parameter int DATA_W  = 19,
   parameter int ADDR_W  = 10,
   parameter int PC_W    = 15,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWriteM,
   input  logic              MemWriteM,
   input  logic [1:0]        ResultSrcM,
   input  logic [4:0]        RDM,
   input  logic [DATA_W-1:0] WriteDataM,
   input  logic [DATA_W-1:0] ALUResultM,
   input  logic [PC_W-1:0]   PCPlus1M,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_m,
   output logic              mem_err,
   output logic              RegWriteW,
   output logic [1:0]        ResultSrcW,
   output logic [4:0]        RDW,
   output logic [DATA_W-1:0] ALUResultW,
   output logic [DATA_W-1:0] ReadDataW,
   output logic [PC_W-1:0]   PCPlus1W
`ifdef MEM_STAGE_PERF_EN
   ,
   output logic [15:0]       load_cnt,
   output logic [15:0]       store_cnt,
   output logic [15:0]       stall_cnt
`endif
);

   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             is_load;
   logic             op;
   logic             timed_out;
   logic             stall_raw;

   // A store wins when both store and load are flagged.
   assign is_load   = ~MemWriteM & (ResultSrcM == 2'b01);
   assign op        = MemWriteM | (ResultSrcM == 2'b01);
   assign timed_out = (state == WAIT) & ~mem_ready & (wait_cnt >= CNT_W'(TIMEOUT));
   assign stall_raw = (state == IDLE) ? (op & ~mem_ready) : (~mem_ready & ~timed_out);

   assign mem_req   = reset & ((state == IDLE) ? op : 1'b1);
   assign stall_m   = reset & stall_raw;
   assign mem_we    = MemWriteM;
   assign mem_addr  = ALUResultM[ADDR_W-1:0];
   assign mem_wdata = WriteDataM;

   // Handshake FSM and MEM/WB register; a stalled cycle pushes a bubble downstream.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         mem_err    <= 1'b0;
         RegWriteW  <= 1'b0;
         ResultSrcW <= 2'b00;
         RDW        <= '0;
         ALUResultW <= '0;
         ReadDataW  <= '0;
         PCPlus1W   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (op && !mem_ready) begin
                  state    <= WAIT;
                  wait_cnt <= CNT_W'(1);
               end else begin
                  wait_cnt <= '0;
               end
            end
            WAIT: begin
               if (mem_ready || timed_out) begin
                  state    <= IDLE;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               wait_cnt <= '0;
            end
         endcase

         if (timed_out) begin
            mem_err <= 1'b1;
         end

         if (stall_raw) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            RDW        <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus1W   <= '0;
         end else begin
            RegWriteW  <= RegWriteM & ~timed_out;
            ResultSrcW <= ResultSrcM;
            RDW        <= RDM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= (is_load && mem_ready) ? mem_rdata : '0;
            PCPlus1W   <= PCPlus1M;
         end
      end
   end

`ifdef MEM_STAGE_PERF_EN
   logic access_done;

   assign access_done = (state == IDLE) ? (op & mem_ready) : (mem_ready | timed_out);

   // Saturating activity counters; aborted accesses still count as accesses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_cnt  <= '0;
         store_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (access_done && is_load && load_cnt != 16'hFFFF) begin
            load_cnt <= load_cnt + 16'd1;
         end
         if (access_done && MemWriteM && store_cnt != 16'hFFFF) begin
            store_cnt <= store_cnt + 16'd1;
         end
         if (stall_raw && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
